mdio_master: RTL and testbench
==============================

Name: mdio_master

Overview:
- Clause-22 MDIO management master that configures the PHYs attached to each mac_controller port of the bridge.
- Accepts one register read/write command at a time through a valid/ready handshake.
- Serialises the command onto MDC/MDIO with a tristate-split MDIO (mdio_o, mdio_oe, mdio_i); the pad tristate sits at bridge top.
- Returns read data and a no-PHY error flag on a one-cycle response strobe.

Parameters:
- CLK_DIV, 4, half-period of MDC in clk cycles; MDC = clk/(2*CLK_DIV); legal range 1..255.
- PREAMBLE_LEN, 32, number of leading '1' bits; 0 = preamble suppression; legal range 0..32.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high when IDLE; command accepted on cmd_valid & cmd_ready
- cmd_write  input  1  1 = write (OP=01), 0 = read (OP=10)
- cmd_phyad  input  5  PHY address
- cmd_regad  input  5  register address
- cmd_wdata  input  16  write data
- rsp_valid  output  1  one-cycle pulse at command completion (read and write)
- rsp_rdata  output  16  read data; held until the next read completes
- rsp_err  output  1  read TA error; valid with rsp_valid; 0 for writes
- mdc  output  1  management clock
- mdio_o  output  1  MDIO drive value
- mdio_oe  output  1  MDIO output enable
- mdio_i  input  1  MDIO sampled value
- busy  output  1  inverse of cmd_ready

Behaviour:
- Reset, asynchronous: state IDLE; cmd_ready=1; busy=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; mdc=0; mdio_o=1; mdio_oe=0; divider and bit counters cleared.
- Reset mid-frame aborts the frame immediately. No rsp_valid is produced for the aborted command.
- Acceptance:
  - All cmd_* fields are latched on the accept cycle t.
  - cmd_valid while busy is ignored, with no queuing. The requester holds cmd_valid until ready.
- Bit timing:
  - Each bit period is 2*CLK_DIV clk cycles. mdc=0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles.
  - mdio_o/mdio_oe update on the first cycle of each bit period (MDC falling).
  - mdio_i is sampled on the cycle mdc rises.
- The first bit period starts at t+1.
- Frame sequence, MSB first:
  - PREAMBLE_LEN x '1'
  - ST=01
  - OP (01 write / 10 read)
  - PHYAD[4:0]
  - REGAD[4:0]
  - TA: write drives 1,0; read releases the line
  - DATA[15:0]
- Frame length: PREAMBLE_LEN + 32 bits.
- State machine, each state advances after its last bit period:
  - IDLE -> PRE, or -> HDR if PREAMBLE_LEN=0
  - PRE -> HDR after PREAMBLE_LEN bits
  - HDR -> TA after 14 bits
  - TA -> DATA after 2 bits
  - DATA -> DONE after 16 bits
  - DONE lasts 1 cycle, then -> IDLE
- mdio_oe:
  - 1 from PRE through end of HDR.
  - Write: stays 1 through TA and DATA.
  - Read: 0 from the first TA bit through end of DATA.
  - 0 in IDLE/DONE, with mdio_o=1.
- Read TA check: the second TA bit sampled must be 0. If it is 1, rsp_err=1.
- Read data: shifts in on 16 MDC rising edges into rsp_rdata, MSB first. rsp_rdata updates in DONE.
- DONE: rsp_valid=1 for exactly one cycle; mdc=0; cmd_ready returns to 1 the following cycle.
- Latency: rsp_valid asserts at cycle t + 1 + (PREAMBLE_LEN+32)*2*CLK_DIV.
- Back-to-back: with cmd_valid held, the next accept happens on the cycle after DONE. mdc stays low at least CLK_DIV+1 cycles between frames.
- mdc stays 0 in IDLE. No spurious edges occur on accept or reset.
- Counters are sized for the maximum parameters. Divider wraps at CLK_DIV-1 without overflow.

Test Plan:
- Write, CLK_DIV=2, PREAMBLE_LEN=32, phyad=1 regad=0 wdata=0x1140:
  - -> 64 MDC rising edges.
  - -> bits sampled at mdc rising = 32x1, 01, 01, 00001, 00000, 10, 0001000101000000.
  - -> mdio_oe=1 throughout.
  - -> rsp_valid at t+257; rsp_err=0.
- Read, phyad=1 regad=2, PHY model drives TA=0 then 0x0141:
  - -> mdio_oe drops at TA start.
  - -> rsp_rdata=0x0141, rsp_err=0 on the rsp_valid cycle.
- Read with mdio_i tied 1 (no PHY):
  - -> rsp_rdata=0xFFFF, rsp_err=1.
- cmd_valid held for two commands:
  - -> cmd_ready=0 during frame 1.
  - -> second accept exactly 1 cycle after the rsp_valid of frame 1.
  - -> mdc low >= CLK_DIV+1 cycles between frames.
- rst_n pulsed low during DATA of a read:
  - -> all outputs return to reset values in the same cycle; no rsp_valid.
  - -> next command after release completes normally.
- PREAMBLE_LEN=0, CLK_DIV=1, write:
  - -> frame starts with ST=01.
  - -> 32 MDC periods.
  - -> rsp_valid at t+65.

Source files
------------

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO master; one register read/write per cmd handshake,
// serialised onto mdc / split-tristate mdio, result returned on a 1-cycle rsp strobe.
// Latency: rsp_valid at accept + 1 + (PREAMBLE_LEN+32)*2*CLK_DIV; cmd_ready only in IDLE.
// Ports: cmd_* request (valid/ready), rsp_* result, mdc/mdio_o/mdio_oe/mdio_i to the pad, busy.
module mdio_master #(
    parameter int CLK_DIV      = 4,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    state_t      state_q, state_d;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic        mdc_q;
    logic        wr_q;
    logic        ta_err;
    logic [31:0] tx_sr;     // ST, OP, PHYAD, REGAD, TA, DATA; MSB goes out first
    logic [15:0] rx_sr;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        accept, in_frame, half_end, bit_end, mdc_rise, last_bit;

    assign accept   = cmd_valid && (state_q == S_IDLE);
    assign in_frame = (state_q == S_PRE) || (state_q == S_HDR) ||
                      (state_q == S_TA)  || (state_q == S_DATA);
    assign half_end = in_frame && (div_cnt == DIV_LAST);
    // mdc_q is the bit-period phase: low half first, high half second.
    assign bit_end  = half_end && mdc_q;
    assign mdc_rise = half_end && !mdc_q;

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = !cmd_ready;
    assign mdc       = mdc_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        last_bit = 1'b0;
        case (state_q)
            S_PRE:   last_bit = (bit_cnt == PRE_LAST);
            S_HDR:   last_bit = (bit_cnt == 6'd13);
            S_TA:    last_bit = (bit_cnt == 6'd1);
            S_DATA:  last_bit = (bit_cnt == 6'd15);
            default: last_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rsp_valid = 1'b0;
        mdio_o    = 1'b1;
        mdio_oe   = 1'b0;
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = (PREAMBLE_LEN == 0) ? S_HDR : S_PRE;
            S_PRE: begin
                mdio_oe = 1'b1;
                if (bit_end && last_bit) state_d = S_HDR;
            end
            S_HDR: begin
                mdio_oe = 1'b1;
                mdio_o  = tx_sr[31];
                if (bit_end && last_bit) state_d = S_TA;
            end
            S_TA, S_DATA: begin
                // reads hand the line to the PHY from the first turnaround bit
                mdio_oe = wr_q;
                mdio_o  = wr_q ? tx_sr[31] : 1'b1;
                if (bit_end && last_bit) state_d = (state_q == S_TA) ? S_DATA : S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            mdc_q   <= 1'b0;
            wr_q    <= 1'b0;
            ta_err  <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            mdc_q   <= 1'b0;
            wr_q    <= cmd_write;
            ta_err  <= 1'b0;
            tx_sr   <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad, cmd_regad,
                        (cmd_write ? 2'b10 : 2'b11), cmd_wdata};
        end else if (in_frame) begin
            if (half_end) begin
                div_cnt <= '0;
                mdc_q   <= !mdc_q;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            if (mdc_rise) begin
                // a PHY that answers pulls the second TA bit low
                if (state_q == S_TA && bit_cnt == 6'd1) ta_err <= mdio_i;
                if (state_q == S_DATA) rx_sr <= {rx_sr[14:0], mdio_i};
            end
            if (bit_end) begin
                bit_cnt <= last_bit ? 6'd0 : bit_cnt + 6'd1;
                if (state_q != S_PRE) tx_sr <= {tx_sr[30:0], 1'b0};
                if (state_q == S_DATA && last_bit) begin
                    err_q <= !wr_q && ta_err;
                    if (!wr_q) rdata_q <= rx_sr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
module tb_mdio_master;
    localparam int CD   = 2;
    localparam int PL   = 32;
    localparam int NB   = PL + 32;
    localparam int CD_B = 1;
    localparam int PL_B = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [4:0]  cmd_phyad = '0, cmd_regad = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_ready, rsp_valid, rsp_err, mdc, mdio_o, mdio_oe, busy;
    logic [15:0] rsp_rdata;
    logic        mdio_i = 1'b1;

    logic        cmd_valid_b = 1'b0, cmd_write_b = 1'b0;
    logic [4:0]  cmd_phyad_b = '0, cmd_regad_b = '0;
    logic [15:0] cmd_wdata_b = '0;
    logic        cmd_ready_b, rsp_valid_b, rsp_err_b, mdc_b, mdio_o_b, mdio_oe_b, busy_b;
    logic [15:0] rsp_rdata_b;
    logic        mdio_i_b = 1'b1;

    mdio_master #(.CLK_DIV(CD), .PREAMBLE_LEN(PL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
        .mdio_i(mdio_i), .busy(busy)
    );

    mdio_master #(.CLK_DIV(CD_B), .PREAMBLE_LEN(PL_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_write(cmd_write_b), .cmd_phyad(cmd_phyad_b), .cmd_regad(cmd_regad_b),
        .cmd_wdata(cmd_wdata_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
        .rsp_err(rsp_err_b), .mdc(mdc_b), .mdio_o(mdio_o_b), .mdio_oe(mdio_oe_b),
        .mdio_i(mdio_i_b), .busy(busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // PHY model state and the expected held read data
    bit          phy_mode = 1'b0;    // 0 = nothing attached (line floats high), 1 = PHY answers
    logic [15:0] phy_data = '0;
    logic [15:0] mdl_rdata = '0;

    // results of the most recent run_frame
    int          r_acc_wait, r_lat, r_nrise, r_rdy_bad;
    logic [15:0] r_rd;
    logic        r_er;
    logic [63:0] r_bits, r_oe;
    bit          r_tmo;

    // mdc low time before the first rising edge following a response
    int low_run = 0, gap_low = -1;
    bit arm = 1'b0, mprev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rsp_valid) arm = 1'b1;
        if (mdc) begin
            if (!mprev && arm) begin
                gap_low = low_run;
                arm = 1'b0;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        mprev = mdc;
    end

    // expected frame, bit i = i-th bit on the wire
    function automatic logic [63:0] exp_frame(int pl, logic wr, logic [4:0] pa, logic [4:0] ra,
                                              logic [15:0] wd);
        bit q[$];
        logic [63:0] v;
        for (int i = 0; i < pl; i++) q.push_back(1'b1);
        q.push_back(1'b0); q.push_back(1'b1);
        if (wr) begin q.push_back(1'b0); q.push_back(1'b1); end
        else    begin q.push_back(1'b1); q.push_back(1'b0); end
        for (int i = 4; i >= 0; i--) q.push_back(pa[i]);
        for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
        q.push_back(1'b1); q.push_back(1'b0);
        for (int i = 15; i >= 0; i--) q.push_back(wd[i]);
        v = '0;
        for (int i = 0; i < q.size(); i++) v[i] = q[i];
        return v;
    endfunction

    function automatic logic [63:0] exp_oe(int pl, logic wr);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < pl + 32; i++) v[i] = (i < pl + 14) || wr;
        return v;
    endfunction

    function automatic int exp_lat(int pl, int cd);
        return 1 + (pl + 32) * 2 * cd;
    endfunction

    // value the PHY presents for wire bit i
    function automatic logic phy_bit(int i);
        if (!phy_mode) return 1'b1;
        if (i == PL + 15) return 1'b0;
        if (i >= PL + 16 && i < PL + 32) return phy_data[15 - (i - PL - 16)];
        return 1'b1;
    endfunction

    // Issue one command on dut, play the PHY, record the wire; abort_at>0 returns early at that cycle.
    task automatic run_frame(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input int abort_at, input bit keep);
        bit acc;
        logic prev;
        int n;
        r_acc_wait = 0; r_lat = 0; r_nrise = 0; r_rdy_bad = 0; r_tmo = 1'b0;
        r_bits = '0; r_oe = '0; r_rd = '0; r_er = 1'b0;
        @(negedge clk);
        cmd_write = wr; cmd_phyad = pa; cmd_regad = ra; cmd_wdata = wd; cmd_valid = 1'b1;
        mdio_i = phy_bit(0);
        acc = 1'b0;
        while (!acc && r_acc_wait < 1000) begin
            @(posedge clk);
            acc = cmd_ready;
            r_acc_wait++;
            #1;
        end
        if (!acc) begin
            r_tmo = 1'b1;
            cmd_valid = 1'b0;
            return;
        end
        n = 1;
        prev = 1'b0;
        while (n < 3000) begin
            if (n == 1 && !keep) cmd_valid = 1'b0;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) r_rdy_bad++;
            if (mdc && !prev) begin
                if (r_nrise < 64) begin
                    r_bits[r_nrise] = mdio_o;
                    r_oe[r_nrise]   = mdio_oe;
                end
                r_nrise++;
                mdio_i = phy_bit(r_nrise);
            end
            prev = mdc;
            if (rsp_valid) begin
                r_lat = n; r_rd = rsp_rdata; r_er = rsp_err;
                break;
            end
            if (abort_at != 0 && n == abort_at) return;
            @(posedge clk);
            #1;
            n++;
        end
        if (r_lat == 0) r_tmo = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid, rsp_rdata, rsp_err, mdc, mdio_o, mdio_oe} !==
            {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_a: rdy/busy/vld/rdata/err/mdc/o/oe got %b %b %b %h %b %b %b %b",
                     cmd_ready, busy, rsp_valid, rsp_rdata, rsp_err, mdc, mdio_o, mdio_oe);
        end
        n_cmp++;
        if ({cmd_ready_b, busy_b, rsp_valid_b, rsp_rdata_b, rsp_err_b, mdc_b, mdio_o_b, mdio_oe_b} !==
            {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_b: rdy/busy/vld/rdata/err/mdc/o/oe got %b %b %b %h %b %b %b %b",
                     cmd_ready_b, busy_b, rsp_valid_b, rsp_rdata_b, rsp_err_b, mdc_b, mdio_o_b, mdio_oe_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (mdc !== 1'b0 || cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_after_reset: mdc=%b cmd_ready=%b want 0 1", mdc, cmd_ready);
        end
    endtask

    task automatic test_write();
        logic [63:0] ef;
        ef = exp_frame(PL, 1'b1, 5'd1, 5'd0, 16'h1140);
        run_frame(1'b1, 5'd1, 5'd0, 16'h1140, 0, 1'b0);
        n_cmp++;
        if (r_tmo !== 1'b0) begin n_bad++; $display("FAIL write_timeout: got %b want 0", r_tmo); end
        n_cmp++;
        if (r_acc_wait !== 1) begin n_bad++; $display("FAIL write_accept: waited %0d want 1", r_acc_wait); end
        n_cmp++;
        if (r_nrise !== 64) begin n_bad++; $display("FAIL write_mdc_edges: got %0d want 64", r_nrise); end
        n_cmp++;
        if (r_bits !== ef) begin n_bad++; $display("FAIL write_bits: got %h want %h", r_bits, ef); end
        n_cmp++;
        if (r_oe !== {64{1'b1}}) begin n_bad++; $display("FAIL write_oe: got %h want all ones", r_oe); end
        n_cmp++;
        if (r_lat !== 257) begin n_bad++; $display("FAIL write_latency: got t+%0d want t+257", r_lat); end
        n_cmp++;
        if (r_er !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b want 0", r_er); end
        n_cmp++;
        if (r_rdy_bad !== 0) begin n_bad++; $display("FAIL write_ready_low: %0d cycles ready while busy want 0", r_rdy_bad); end
    endtask

    task automatic test_read();
        logic [63:0] ef, eo;
        phy_mode = 1'b1;
        phy_data = 16'h0141;
        ef = exp_frame(PL, 1'b0, 5'd1, 5'd2, 16'h0000);
        eo = exp_oe(PL, 1'b0);
        run_frame(1'b0, 5'd1, 5'd2, 16'h0000, 0, 1'b0);
        mdl_rdata = 16'h0141;
        n_cmp++;
        if (r_oe !== eo) begin n_bad++; $display("FAIL read_oe: got %h want %h", r_oe, eo); end
        n_cmp++;
        if ((r_bits & eo) !== (ef & eo)) begin
            n_bad++; $display("FAIL read_hdr_bits: got %h want %h", r_bits & eo, ef & eo);
        end
        n_cmp++;
        if (r_rd !== 16'h0141 || r_er !== 1'b0) begin
            n_bad++; $display("FAIL read_data: got %h err %b want 0141 err 0", r_rd, r_er);
        end
        n_cmp++;
        if (r_lat !== exp_lat(PL, CD)) begin
            n_bad++; $display("FAIL read_latency: got %0d want %0d", r_lat, exp_lat(PL, CD));
        end
    endtask

    task automatic test_no_phy();
        phy_mode = 1'b0;
        run_frame(1'b0, 5'd7, 5'd3, 16'h0000, 0, 1'b0);
        mdl_rdata = 16'hFFFF;
        n_cmp++;
        if (r_rd !== 16'hFFFF || r_er !== 1'b1) begin
            n_bad++; $display("FAIL no_phy: got %h err %b want ffff err 1", r_rd, r_er);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, rdy1;
        phy_mode = 1'b1;
        phy_data = 16'(($urandom_range(65535, 0)));
        run_frame(1'b1, 5'd3, 5'd4, 16'hBEEF, 0, 1'b1);
        lat1 = r_lat;
        rdy1 = r_rdy_bad;
        run_frame(1'b0, 5'd5, 5'd6, 16'h0000, 0, 1'b0);
        mdl_rdata = phy_data;
        n_cmp++;
        if (rdy1 !== 0 || lat1 !== exp_lat(PL, CD)) begin
            n_bad++; $display("FAIL b2b_frame1: ready-high cycles %0d lat %0d want 0 %0d", rdy1, lat1, exp_lat(PL, CD));
        end
        // rsp_valid cycle D: DONE still refuses, IDLE at D+1 accepts -> second polled edge
        n_cmp++;
        if (r_acc_wait !== 2) begin n_bad++; $display("FAIL b2b_accept: edges waited %0d want 2", r_acc_wait); end
        n_cmp++;
        if (gap_low < CD + 1) begin n_bad++; $display("FAIL b2b_mdc_gap: low %0d cycles want >= %0d", gap_low, CD + 1); end
        n_cmp++;
        if (r_rd !== phy_data || r_er !== 1'b0) begin
            n_bad++; $display("FAIL b2b_read: got %h err %b want %h err 0", r_rd, r_er, phy_data);
        end
    endtask

    task automatic test_reset_mid();
        phy_mode = 1'b1;
        phy_data = 16'h5A3C;
        run_frame(1'b0, 5'd2, 5'd9, 16'h0000, 1 + 50 * 2 * CD + 1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mdl_rdata = 16'h0000;
        n_cmp++;
        if ({cmd_ready, busy, rsp_valid, rsp_rdata, rsp_err, mdc, mdio_o, mdio_oe} !==
            {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_outputs: rdy/busy/vld/rdata/err/mdc/o/oe got %b %b %b %h %b %b %b %b",
                     cmd_ready, busy, rsp_valid, rsp_rdata, rsp_err, mdc, mdio_o, mdio_oe);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (i % 100 == 0) begin
                n_cmp++;
                if (rsp_valid !== 1'b0 || mdc !== 1'b0) begin
                    n_bad++; $display("FAIL abort_quiet: rsp_valid %b mdc %b at %0d want 0 0", rsp_valid, mdc, i);
                end
            end
        end
        run_frame(1'b0, 5'd2, 5'd9, 16'h0000, 0, 1'b0);
        mdl_rdata = phy_data;
        n_cmp++;
        if (r_rd !== 16'h5A3C || r_er !== 1'b0 || r_lat !== exp_lat(PL, CD)) begin
            n_bad++; $display("FAIL after_abort: got %h err %b lat %0d want 5a3c err 0 lat %0d",
                              r_rd, r_er, r_lat, exp_lat(PL, CD));
        end
    endtask

    task automatic test_random();
        logic wr;
        logic [4:0] pa, ra;
        logic [15:0] wd;
        logic [63:0] ef, eo;
        logic e_er;
        for (int k = 0; k < 6; k++) begin
            wr = 1'($urandom_range(1, 0));
            pa = 5'($urandom_range(31, 0));
            ra = 5'($urandom_range(31, 0));
            wd = 16'($urandom_range(65535, 0));
            phy_mode = ($urandom_range(3, 0) != 0);
            phy_data = 16'($urandom_range(65535, 0));
            ef = exp_frame(PL, wr, pa, ra, wd);
            eo = exp_oe(PL, wr);
            run_frame(wr, pa, ra, wd, 0, 1'b0);
            e_er = 1'b0;
            if (!wr) begin
                mdl_rdata = phy_mode ? phy_data : 16'hFFFF;
                e_er = !phy_mode;
            end
            n_cmp++;
            if (r_lat !== exp_lat(PL, CD) || r_oe !== eo || (r_bits & eo) !== (ef & eo)) begin
                n_bad++; $display("FAIL rand_frame[%0d]: lat %0d oe %h bits %h want lat %0d oe %h bits %h",
                                  k, r_lat, r_oe, r_bits & eo, exp_lat(PL, CD), eo, ef & eo);
            end
            n_cmp++;
            if (r_rd !== mdl_rdata || r_er !== e_er) begin
                n_bad++; $display("FAIL rand_rsp[%0d]: got %h err %b want %h err %b", k, r_rd, r_er, mdl_rdata, e_er);
            end
        end
    endtask

    task automatic test_nopre();
        logic [4:0] pa, ra;
        logic [15:0] wd;
        logic [63:0] ob, ef;
        int n, nr, lat, w;
        logic prev;
        bit acc;
        pa = 5'($urandom_range(31, 0));
        ra = 5'($urandom_range(31, 0));
        wd = 16'($urandom_range(65535, 0));
        ef = exp_frame(PL_B, 1'b1, pa, ra, wd);
        @(negedge clk);
        cmd_write_b = 1'b1; cmd_phyad_b = pa; cmd_regad_b = ra; cmd_wdata_b = wd; cmd_valid_b = 1'b1;
        acc = 1'b0;
        w = 0;
        while (!acc && w < 100) begin
            @(posedge clk);
            acc = cmd_ready_b;
            w++;
            #1;
        end
        cmd_valid_b = 1'b0;
        n = 1; nr = 0; lat = 0; prev = 1'b0; ob = '0;
        while (acc && n < 500) begin
            if (mdc_b && !prev) begin
                if (nr < 64) ob[nr] = mdio_o_b;
                nr++;
            end
            prev = mdc_b;
            if (rsp_valid_b) begin lat = n; break; end
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (lat !== exp_lat(PL_B, CD_B)) begin n_bad++; $display("FAIL nopre_latency: got t+%0d want t+%0d", lat, exp_lat(PL_B, CD_B)); end
        n_cmp++;
        if (nr !== 32) begin n_bad++; $display("FAIL nopre_mdc_edges: got %0d want 32", nr); end
        n_cmp++;
        if (ob[0] !== 1'b0 || ob[1] !== 1'b1) begin n_bad++; $display("FAIL nopre_start: got %b%b want 01", ob[0], ob[1]); end
        n_cmp++;
        if (ob !== ef) begin n_bad++; $display("FAIL nopre_bits: got %h want %h", ob, ef); end
        n_cmp++;
        if (rsp_err_b !== 1'b0 || mdio_oe_b !== 1'b0) begin
            n_bad++; $display("FAIL nopre_done: err %b oe %b want 0 0", rsp_err_b, mdio_oe_b);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_no_phy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_nopre();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
